// File: rtl/uart_rx.sv
// UART receive engine: 2-flop synchronizer, start detect, mid-bit sampling.
// Ports: clk, reset (async low), rx, k, eight/pen/ohel in; rx_data, rdy, perr, ferr, ovf out.
module uart_rx #(
  parameter int K_W = 20
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx,
  input  logic [K_W-1:0] k,
  input  logic           eight,
  input  logic           pen,
  input  logic           ohel,
  input  logic           clr_rdy,
  output logic [7:0]     rx_data,
  output logic           rdy,
  output logic           perr,
  output logic           ferr,
  output logic           ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;

  localparam logic [K_W-1:0] ONE = K_W'(1);

  logic           r_sync1;
  logic           r_rx_s;
  logic           r_prev;
  logic [1:0]     r_state;
  logic [K_W-1:0] r_cnt;
  logic [3:0]     r_bit;
  logic [9:0]     r_shift;
  logic [K_W-1:0] r_k;
  logic           r_eight;
  logic           r_pen;
  logic           r_ohel;

  logic           w_fall;
  logic           w_tick;
  logic [3:0]     w_n;
  logic [3:0]     w_shamt;
  logic           w_last;
  logic [9:0]     w_frame;
  logic [8:0]     w_full;
  logic [7:0]     w_data;
  logic           w_par;
  logic           w_perr;
  logic [K_W-1:0] w_half;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
      r_prev  <= r_rx_s;
    end
  end

  assign w_fall  = r_prev & ~r_rx_s;
  assign w_tick  = (r_cnt == '0);
  assign w_half  = (k >> 1) - ONE;
  assign w_n     = 4'd8 + {3'd0, r_eight}
                 + {3'd0, r_pen};
  assign w_last  = (r_state == S_DATA) & w_tick
                 & (r_bit == w_n - 4'd1);

  // Frame bits enter at the top and move down, so after n
  // samples bit j sits at 10-n+j; shift down to align at 0.
  assign w_frame = {r_rx_s, r_shift[9:1]};
  assign w_shamt = 4'd10 - w_n;
  assign w_full  = 9'(w_frame >> w_shamt);
  assign w_data  = r_eight ? w_full[7:0]
                           : {1'b0, w_full[6:0]};
  assign w_par   = r_eight ? w_full[8] : w_full[7];
  assign w_perr  = r_pen & (^w_data ^ w_par ^ r_ohel);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_k     <= '0;
      r_eight <= 1'b0;
      r_pen   <= 1'b0;
      r_ohel  <= 1'b0;
    end else begin
      unique case (1'b1)
        (r_state == S_IDLE): begin
          if (w_fall) begin
            r_state <= S_START;
            r_cnt   <= w_half;
            r_bit   <= '0;
            r_k     <= k;
            r_eight <= eight;
            r_pen   <= pen;
            r_ohel  <= ohel;
          end
        end
        (r_state == S_START): begin
          if (w_tick) begin
            r_cnt   <= r_k - ONE;
            r_state <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        (r_state == S_DATA): begin
          if (w_tick) begin
            r_shift <= w_frame;
            r_bit   <= r_bit + 4'd1;
            r_cnt   <= r_k - ONE;
            if (w_last) r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A load beats a same-cycle acknowledge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data <= '0;
      rdy     <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else if (w_last) begin
      rx_data <= w_data;
      rdy     <= 1'b1;
      perr    <= w_perr;
      ferr    <= ~r_rx_s;
      ovf     <= rdy & ~clr_rdy;
    end else if (clr_rdy) begin
      rdy  <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
      ovf  <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive half of the full UART, the counterpart of the transmit engine. Recovers asynchronous frames from the `rx` line: start bit, 7 or 8 data bits LSB first, optional parity, one stop bit. Uses the same bit-time count `k` and frame configuration (`eight`, `pen`, `ohel`) that the TSI register interface supplies to the transmitter. Each completed byte is presented with `rdy` and error flags until the host acknowledges with `clr_rdy`.

## Interface
- `K_W`, default 20: width of the bit-time count `k`.
- `clk`  in  1  100 MHz system clock.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `k`  in  K_W  bit time in `clk` cycles; legal range ≥ 4.
- `eight`  in  1  1 = 8 data bits, 0 = 7 data bits.
- `pen`  in  1  parity enable.
- `ohel`  in  1  parity sense: 1 = odd, 0 = even. Ignored when `pen` = 0.
- `clr_rdy`  in  1  single-cycle host acknowledge; clears `rdy`, `perr`, `ferr` and `ovf`.
- `rx_data`  out  8  received byte; bit 7 = 0 in 7-bit mode.
- `rdy`  out  1  byte available.
- `perr`  out  1  parity error on the held byte.
- `ferr`  out  1  framing error (stop bit sampled 0).
- `ovf`  out  1  overrun: a new byte was loaded while `rdy` was already 1.

## Operation
- **Synchronizer:** `rx` passes through 2 flops to produce `rx_s`. Both flops reset to 1.
- **Counters:**
  - Bit-time counter: K_W bits, reloads on every sample.
  - Bit counter: 4 bits, counts samples after the start bit.
  - Frame length `n` = (`eight` ? 8 : 7) + `pen` + 1. Legal values are 8..10.
- **Frame latch:** `k`, `eight`, `pen` and `ohel` are latched at start detection. Changes mid-frame do not affect the frame in progress.
- **FSM: IDLE → START → DATA → IDLE.**
  - IDLE: stay until a falling edge on `rx_s` (previous cycle 1, current 0). A line held low does not retrigger.
  - START: wait `k>>1` cycles, then sample `rx_s`.
    - Sample = 1: false start; return to IDLE with no output change.
    - Sample = 0: go to DATA.
  - DATA: every `k` cycles, sample `rx_s` and shift it into an 10-bit shift register, LSB first. After the n-th sample (the stop bit), go to IDLE.
- **Load on the n-th sample.** All four outputs below update together on the next edge:
  - `rx_data` ← data bits.
  - `perr` ← `pen` & (XOR of data bits ^ parity bit ^ `ohel`) ≠ 0. This means an odd total count of ones is correct when `ohel` = 1.
  - `ferr` ← ~stop.
  - `ovf` ← `rdy` & ~`clr_rdy`.
  - `rdy` ← 1.
- **Simultaneous load and `clr_rdy`:** the load wins. `rdy` = 1, with flags from the new frame.
- **Ack with no load:** `clr_rdy` clears `rdy`, `perr`, `ferr` and `ovf`. `rx_data` holds its value.
- **Reset:** IDLE, counters 0, shift register 0. All outputs 0, including `rx_data` = 0x00. Reset asserted mid-frame discards the frame.

## Timing
- `t0` = first cycle with `rx_s` = 0 in IDLE. This is 2–3 cycles after the `rx` edge.
- Start sample at `t0 + (k>>1)`.
- Data bit i (i = 0..n-1) sampled at `t0 + (k>>1) + (i+1)·k`.
- Outputs valid at `t0 + (k>>1) + n·k + 1`.
  - 8N1 with `k` = 868 gives `t0` + 8247.
- FSM is back in IDLE in the middle of the stop bit, so back-to-back frames are accepted with no idle gap.
- Errors of ±1 cycle in a sample position are not allowed; the bench checks sample cycles exactly.

## Test plan
- **8N1 good frame:** `k` = 868, `eight` = 1, `pen` = 0, send 0xA5 with stop = 1 → at `t0` + 8247, `rx_data` = 0xA5, `rdy` = 1, `perr` = `ferr` = `ovf` = 0. Then `clr_rdy` → `rdy` = 0 next cycle and `rx_data` stays 0xA5.
- **Parity:**
  - `k` = 16, 8 data bits, `pen` = 1, `ohel` = 1, send 0x03 with parity bit 0 → `perr` = 1.
  - Same byte with parity bit 1 → `perr` = 0.
  - 7 data bits, even parity, 0x55 with parity 0 → `rx_data` = 0x55, `perr` = 0.
- **Glitch and break:**
  - `k` = 16, `rx` low for 5 cycles → no `rdy`, FSM returns to IDLE.
  - Frame with stop = 0, then `rx` held low for 20 bit times → exactly one load, with `ferr` = 1.
- **Overrun and collision:**
  - Two back-to-back frames 0x11 then 0x22, no `clr_rdy` → `rx_data` = 0x22, `ovf` = 1.
  - `clr_rdy` pulsed on the exact load cycle of the second frame → `rdy` = 1, `ovf` = 0.
- **Reset mid-frame:** pull `reset` low during data bit 3, release while the line is idle → all outputs 0. The next 0x5A frame is received correctly.
- **Config change mid-frame:** change `eight` 1 → 0 during a frame → the frame completes as 8-bit; the following frame uses 7-bit.
